// File: rtl/fetcher.sv
`default_nettype none
// ============================================================================
// Module      : fetcher
// Description : Instruction fetch unit. Issues one instruction read at a time
//               to the memory controller, predicts the next PC from the
//               fetched word (JAL taken, backward branches taken, everything
//               else falls through) and hands each instruction to the
//               dispatcher with a one-cycle valid pulse. Supports ROB
//               rollback, downstream back-pressure and a global enable.
//               Optional macro ICACHE_EN adds a direct-mapped one-word-per-
//               entry instruction cache in front of the memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
module fetcher #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_IDX_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  output logic        enable_to_memctrl,
  output logic [31:0] addr_to_memctrl,
  input  logic        ready_from_memctrl,
  input  logic [31:0] inst_from_memctrl,
  output logic        idle_to_dispatcher,
  output logic [31:0] inst_to_dispatcher,
  output logic [31:0] inst_pos_to_dispatcher,
  output logic        if_jump_flag_predicted_to_dispatcher,
  output logic [31:0] rollback_pos_to_dispatcher,
  input  logic        is_full_from_rs,
  input  logic        full_flag_from_lsb,
  input  logic        full_flag_from_rob,
  input  logic        rollback_flag_from_rob,
  input  logic [31:0] rollback_pc_from_rob
);

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        enable_q, enable_d;
  logic [31:0] addr_q, addr_d;
  logic        idle_q, idle_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pos_q, pos_d;
  logic        flag_q, flag_d;
  logic [31:0] rb_pos_q, rb_pos_d;

  logic        stall;
  logic        cache_hit;
  logic [31:0] cache_word;
  logic        fill_en;

  logic [31:0] fetched_word;
  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] pc_plus4;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic [31:0] pred_rb_pos;

  // Any full downstream queue blocks new requests (but not one in flight).
  assign stall = is_full_from_rs | full_flag_from_lsb | full_flag_from_rob;

`ifdef ICACHE_EN
  localparam int DEPTH = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

  logic [DEPTH-1:0]        cache_valid_q;
  logic [TAG_W-1:0]        cache_tag_q  [DEPTH];
  logic [31:0]             cache_data_q [DEPTH];
  logic [ICACHE_IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0]        pc_tag;

  assign pc_idx     = pc_q[ICACHE_IDX_W+1:2];
  assign pc_tag     = pc_q[31:ICACHE_IDX_W+2];
  assign cache_hit  = cache_valid_q[pc_idx] && (cache_tag_q[pc_idx] == pc_tag);
  assign cache_word = cache_data_q[pc_idx];

  // Valid bits are the only cache state that must be cleared by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cache_valid_q <= '0;
    end else if (fill_en) begin
      cache_valid_q[pc_idx] <= 1'b1;
    end
  end

  // Tag/data fill from a completed, non-discarded memctrl read; pc_q still
  // holds the request PC while in WAIT.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      cache_tag_q[pc_idx]  <= pc_tag;
      cache_data_q[pc_idx] <= inst_from_memctrl;
    end
  end
`else
  logic unused_cfg;

  assign cache_hit  = 1'b0;
  assign cache_word = 32'h0;
  assign unused_cfg = fill_en ^ (ICACHE_IDX_W != 0);
`endif

  // Decode the word being delivered and predict the next PC and the
  // alternate (rollback) path.
  always_comb begin
    fetched_word = (state_q == ST_WAIT) ? inst_from_memctrl : cache_word;
    imm_j        = {{11{fetched_word[31]}}, fetched_word[31], fetched_word[19:12],
                    fetched_word[20], fetched_word[30:21], 1'b0};
    imm_b        = {{19{fetched_word[31]}}, fetched_word[31], fetched_word[7],
                    fetched_word[30:25], fetched_word[11:8], 1'b0};
    pc_plus4     = pc_q + 32'd4;
    pred_taken   = 1'b0;
    pred_next_pc = pc_plus4;
    pred_rb_pos  = pc_plus4;
    if (fetched_word[6:0] == OPC_JAL) begin
      pred_taken   = 1'b1;
      pred_next_pc = pc_q + imm_j;
    end else if (fetched_word[6:0] == OPC_BRANCH) begin
      if (imm_b[31]) begin
        pred_taken   = 1'b1;
        pred_next_pc = pc_q + imm_b;
      end else begin
        pred_rb_pos  = pc_q + imm_b;
      end
    end
  end

  // Next-state and output logic; rollback always wins and suppresses delivery.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    enable_d = enable_q;
    addr_d   = addr_q;
    idle_d   = 1'b0;
    inst_d   = inst_q;
    pos_d    = pos_q;
    flag_d   = flag_q;
    rb_pos_d = rb_pos_q;
    fill_en  = 1'b0;

    if (!rdy_in) begin
      idle_d = idle_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rollback_flag_from_rob) begin
            pc_d = rollback_pc_from_rob;
          end else if (!stall) begin
            if (cache_hit) begin
              idle_d   = 1'b1;
              inst_d   = fetched_word;
              pos_d    = pc_q;
              flag_d   = pred_taken;
              rb_pos_d = pred_rb_pos;
              pc_d     = pred_next_pc;
            end else begin
              enable_d = 1'b1;
              addr_d   = pc_q;
              state_d  = ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (rollback_flag_from_rob) begin
            pc_d = rollback_pc_from_rob;
            if (ready_from_memctrl) begin
              enable_d = 1'b0;
              state_d  = ST_IDLE;
            end else begin
              state_d  = ST_DISCARD;
            end
          end else if (ready_from_memctrl) begin
            enable_d = 1'b0;
            idle_d   = 1'b1;
            inst_d   = fetched_word;
            pos_d    = pc_q;
            flag_d   = pred_taken;
            rb_pos_d = pred_rb_pos;
            pc_d     = pred_next_pc;
            fill_en  = 1'b1;
            state_d  = ST_IDLE;
          end
        end

        ST_DISCARD: begin
          if (rollback_flag_from_rob) begin
            pc_d = rollback_pc_from_rob;
          end
          if (ready_from_memctrl) begin
            enable_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end

        default: begin
          enable_d = 1'b0;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      enable_q <= 1'b0;
      addr_q   <= 32'h0;
      idle_q   <= 1'b0;
      inst_q   <= 32'h0;
      pos_q    <= 32'h0;
      flag_q   <= 1'b0;
      rb_pos_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      enable_q <= enable_d;
      addr_q   <= addr_d;
      idle_q   <= idle_d;
      inst_q   <= inst_d;
      pos_q    <= pos_d;
      flag_q   <= flag_d;
      rb_pos_q <= rb_pos_d;
    end
  end

  assign enable_to_memctrl                    = enable_q;
  assign addr_to_memctrl                      = addr_q;
  assign idle_to_dispatcher                   = idle_q;
  assign inst_to_dispatcher                   = inst_q;
  assign inst_pos_to_dispatcher               = pos_q;
  assign if_jump_flag_predicted_to_dispatcher = flag_q;
  assign rollback_pos_to_dispatcher           = rb_pos_q;

endmodule
`default_nettype wire
